// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and defaults for the shift-chain sequencer.
//   state_t      : IDLE / SHIFT / RESP sequencer states
//   OP_LOAD/READ : command opcodes carried on cmd_op_i
//   *_DEF        : default WIDTH / CLK_DIV parameter values
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_READ = 1'b1;

  localparam int WIDTH_DEF   = 4;
  localparam int CLK_DIV_DEF = 1;

endpackage

// File: rtl/shift_tick_gen.sv
// shift_tick_gen: CLK_DIV slot divider for the shift sequencer.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous clear (command accept)
//   en   : count enable (sequencer in SHIFT)
//   tick : one-cycle pulse on the last cycle of each shift slot
module shift_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] div;

  assign tick = en && (div == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div <= '0;
    end else if (en) begin
      // wrap at the slot end so back-to-back slots stay CLK_DIV apart
      div <= tick ? 8'd0 : div + 8'd1;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer for a serial shift-register chain.
// Accepts a word on a valid/ready command port, shifts it (or recirculates
// the chain for READ) over WIDTH enabled slots, and returns the chain's
// previous contents on a valid/ready response port.
//   CLK, Reset         : clock / synchronous active-high reset
//   cmd_valid_i/ready_o: command handshake; cmd_op_i 0=LOAD 1=READ
//   cmd_data_i         : LOAD word, MSB shifted first
//   ser_data_o/ser_en_o: serial data and shift enable to the chain
//   ser_data_i         : chain serial output (MSB stage)
//   rsp_valid_o/ready_i: response handshake; rsp_data_o prior contents
//   busy_o             : high outside IDLE
// Optional macro SHIFT_SEQ_CTRL_PARITY_EN adds rsp_parity_o / cmd_parity_o.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic             ser_data_o,
  output logic             ser_en_o,
  input  logic             ser_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             busy_o
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  ,
  output logic             rsp_parity_o,
  output logic             cmd_parity_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic             op_q;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] rsp_q;
  logic [CW-1:0]    bit_cnt;
  logic             accept;
  logic             tick;
  logic             last;

  assign accept = cmd_valid_i && (state == IDLE);
  assign last   = tick && (bit_cnt == CW'(WIDTH - 1));

  shift_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (CLK),
    .rst  (Reset),
    .clr  (accept),
    .en   (state == SHIFT),
    .tick (tick)
  );

  always_comb begin
    state_nxt   = state;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) state_nxt = SHIFT;
      end
      SHIFT: if (last) state_nxt = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // READ feeds the chain's own output back in, so contents survive the pass
  assign ser_en_o   = tick;
  assign ser_data_o = tick ? ((op_q == OP_READ) ? ser_data_i : shreg[WIDTH-1]) : 1'b0;
  assign rsp_data_o = rsp_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      op_q    <= OP_LOAD;
      shreg   <= '0;
      cap     <= '0;
      rsp_q   <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= cmd_op_i;
        shreg   <= cmd_data_i;
        bit_cnt <= '0;
      end else if (tick) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        cap     <= {cap[WIDTH-2:0], ser_data_i};
        bit_cnt <= bit_cnt + CW'(1);
        // separate response register keeps rsp_data_o stable across later commands
        if (last) rsp_q <= {cap[WIDTH-2:0], ser_data_i};
      end
    end
  end

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic cmd_par_q;

  always_ff @(posedge CLK) begin
    if (Reset)       cmd_par_q <= 1'b0;
    else if (accept) cmd_par_q <= (cmd_op_i == OP_LOAD) ? ^cmd_data_i : 1'b0;
  end

  assign cmd_parity_o = cmd_par_q;
  assign rsp_parity_o = ^rsp_q;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic       CLK;
  logic       Reset;
  // dut: WIDTH=4, CLK_DIV=1
  logic       cv, cr, cop, sdo, sen, sdi, rv, rr, busy;
  logic [3:0] cd, rd;
  // dut3: WIDTH=4, CLK_DIV=3
  logic       cv3, cr3, cop3, sdo3, sen3, sdi3, rv3, rr3, busy3;
  logic [3:0] cd3, rd3;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic       rpar, cpar, rpar3, cpar3;
`endif

  logic [3:0] chain, chain3;
  int         errors = 0;
  int         checks = 0;

  shift_seq_ctrl #(.WIDTH(4), .CLK_DIV(1)) dut (
    .CLK(CLK), .Reset(Reset),
    .cmd_valid_i(cv), .cmd_ready_o(cr), .cmd_op_i(cop), .cmd_data_i(cd),
    .ser_data_o(sdo), .ser_en_o(sen), .ser_data_i(sdi),
    .rsp_valid_o(rv), .rsp_ready_i(rr), .rsp_data_o(rd), .busy_o(busy)
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    , .rsp_parity_o(rpar), .cmd_parity_o(cpar)
`endif
  );

  shift_seq_ctrl #(.WIDTH(4), .CLK_DIV(3)) dut3 (
    .CLK(CLK), .Reset(Reset),
    .cmd_valid_i(cv3), .cmd_ready_o(cr3), .cmd_op_i(cop3), .cmd_data_i(cd3),
    .ser_data_o(sdo3), .ser_en_o(sen3), .ser_data_i(sdi3),
    .rsp_valid_o(rv3), .rsp_ready_i(rr3), .rsp_data_o(rd3), .busy_o(busy3)
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    , .rsp_parity_o(rpar3), .cmd_parity_o(cpar3)
`endif
  );

  // behavioural chains, shifting toward the MSB only when enabled
  always @(posedge CLK) begin
    if (Reset) chain <= '0;
    else if (sen) chain <= {chain[2:0], sdo};
  end
  always @(posedge CLK) begin
    if (Reset) chain3 <= '0;
    else if (sen3) chain3 <= {chain3[2:0], sdo3};
  end
  assign sdi  = chain[3];
  assign sdi3 = chain3[3];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One command on dut (CLK_DIV=1); rsp_ready withheld for 'hold' RESP cycles.
  task automatic do_cmd(input logic op, input logic [3:0] d, input logic [3:0] exp_ser,
                        input logic [3:0] exp_rsp, input int hold);
    cv = 1'b1; cop = op; cd = d; rr = 1'b0;
    step();                       // accept edge = cycle 0
    cv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("shift_en", sen, 1'b1);
      chk("shift_data", sdo, exp_ser[3-i]);
      chk("shift_cmd_ready", cr, 1'b0);
      chk("shift_busy", busy, 1'b1);
      step();
    end
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", rv, 1'b1);
      chk("resp_data", rd, exp_rsp);
      chk("resp_en", sen, 1'b0);
      chk("resp_cmd_ready", cr, 1'b0);
      chk("resp_busy", busy, 1'b1);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      chk("resp_parity", rpar, ^exp_rsp);
`endif
      if (h == hold) rr = 1'b1;
      step();
    end
    rr = 1'b0;
    chk("post_valid", rv, 1'b0);
    chk("post_cmd_ready", cr, 1'b1);
    chk("post_busy", busy, 1'b0);
    chk("post_data_hold", rd, exp_rsp);
  endtask

  initial begin
    Reset = 1'b1;
    cv = 0; cop = 0; cd = '0; rr = 0;
    cv3 = 0; cop3 = 0; cd3 = '0; rr3 = 0;
    step();
    step();
    chk("rst_cmd_ready", cr, 1'b1);
    chk("rst_en", sen, 1'b0);
    chk("rst_sdata", sdo, 1'b0);
    chk("rst_rsp_valid", rv, 1'b0);
    chk("rst_rsp_data", rd, 4'h0);
    chk("rst_busy", busy, 1'b0);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    chk("rst_rpar", rpar, 1'b0);
    chk("rst_cpar", cpar, 1'b0);
`endif
    Reset = 1'b0;

    // LOAD 0xA over empty chain
    do_cmd(1'b0, 4'hA, 4'b1010, 4'h0, 0);
    chk("load_a_chain", chain, 4'hA);

    // READ is non-destructive
    do_cmd(1'b1, 4'h0, 4'b1010, 4'hA, 0);
    chk("read_chain", chain, 4'hA);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    chk("read_cpar", cpar, 1'b0);
`endif

    // LOAD 0x5 with backpressure on the response
    do_cmd(1'b0, 4'h5, 4'b0101, 4'hA, 3);
    chk("load_5_chain", chain, 4'h5);

    // LOAD 0x7 then LOAD 0xB (parity case)
    do_cmd(1'b0, 4'h7, 4'b0111, 4'h5, 0);
    do_cmd(1'b0, 4'hB, 4'b1011, 4'h7, 0);
    chk("load_b_chain", chain, 4'hB);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    chk("load_b_cpar", cpar, 1'b1);
    chk("load_b_rpar", rpar, 1'b1);
`endif

    // Reset during cycle 2 of a LOAD
    cv = 1'b1; cop = 1'b0; cd = 4'h6;
    step();                       // edge 0
    cv = 1'b0;
    step();                       // cycle 2
    Reset = 1'b1;
    step();                       // cycle 3
    Reset = 1'b0;
    chk("mid_rst_en", sen, 1'b0);
    chk("mid_rst_valid", rv, 1'b0);
    chk("mid_rst_cmd_ready", cr, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("mid_rst_no_rsp", rv, 1'b0);
      step();
    end

    // CLK_DIV=3 LOAD 0xF; response consumed immediately
    cv3 = 1'b1; cop3 = 1'b0; cd3 = 4'hF; rr3 = 1'b1;
    step();                       // edge 0
    cv3 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("div3_en_c%0d", c), sen3, (c % 3 == 0) && (c <= 12));
      chk($sformatf("div3_valid_c%0d", c), rv3, c == 13);
      if (sen3) chk("div3_sdata", sdo3, 1'b1);
      if (c == 13) chk("div3_rsp_data", rd3, 4'h0);
      step();
    end
    chk("div3_chain", chain3, 4'hF);
    chk("div3_cmd_ready", cr3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer for the serial shift-register chain. Takes a parallel word through a valid/ready command port and drives the chain's serial input plus a shift enable for exactly WIDTH shift slots. While shifting, it captures the chain's serial output, so the prior register contents come back on a valid/ready response port. Sits between the control bus and the shift-register datapath; the datapath shifts only when ser_en_o is high.

Parameters:
WIDTH, 4, chain length in bits; also the command and response data width; legal range 2..32
CLK_DIV, 1, clock cycles per shift slot; legal range 1..255

Ports:
CLK  in  1  clock; all logic on the rising edge
Reset  in  1  synchronous, active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid and ready are both high at the edge
cmd_op_i  in  1  0 = LOAD (shift cmd_data_i in), 1 = READ (recirculate, non-destructive)
cmd_data_i  in  WIDTH  word to load; MSB is shifted first
ser_data_o  out  1  to the chain's serial input
ser_en_o  out  1  shift enable to the chain
ser_data_i  in  1  from the chain's serial output (MSB stage)
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid and ready are both high at the edge
rsp_data_o  out  WIDTH  chain contents before the command, MSB first
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, active-high): state = IDLE; divider and bit counter = 0; capture register = 0.
  - Outputs after reset: cmd_ready_o=1, ser_en_o=0, ser_data_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0.
- States: IDLE -> SHIFT -> RESP -> IDLE.
- IDLE:
  - cmd_ready_o=1.
  - On handshake: latch cmd_op_i, latch cmd_data_i into shreg, clear the counters, enter SHIFT. The accept edge is cycle 0.
- SHIFT:
  - cmd_ready_o=0.
  - Divider counts 0..CLK_DIV-1. ser_en_o=1 only when divider == CLK_DIV-1.
  - In an enabled cycle:
    - LOAD: ser_data_o = shreg[WIDTH-1], and shreg shifts left.
    - READ: ser_data_o = ser_data_i, so the contents are restored after WIDTH shifts.
    - Capture register <= {capture[WIDTH-2:0], ser_data_i}; bit counter increments.
  - ser_data_o = 0 whenever ser_en_o = 0.
  - After the WIDTH-th enabled cycle, enter RESP.
- Timing: enable pulses fall in cycles k*CLK_DIV for k = 1..WIDTH. rsp_valid_o rises in cycle WIDTH*CLK_DIV+1.
- RESP:
  - rsp_valid_o=1, rsp_data_o = capture; both held stable until rsp_ready_i.
  - On handshake, go to IDLE; cmd_ready_o=1 in the following cycle. There is no same-cycle bypass of a new command.
  - If rsp_ready_i is already high on entry, the response completes in one cycle.
- Command inputs are ignored outside IDLE.
- rsp_data_o holds its last value after the handshake. It is reset only by Reset.
- Reset mid-operation (SHIFT or RESP): next cycle is IDLE. ser_en_o=0, any pending response is dropped, and the partial shift is not completed. Chain contents are whatever the chain's own reset makes them.
- The divider wraps from CLK_DIV-1 to 0. With CLK_DIV=1, ser_en_o is high for WIDTH consecutive cycles.

Optional Feature:
SHIFT_SEQ_CTRL_PARITY_EN
- Defined:
  - Adds output rsp_parity_o (1 bit) = XOR of rsp_data_o, valid while rsp_valid_o is high.
  - Adds output cmd_parity_o (1 bit) = XOR of the latched LOAD word. It is 0 for READ and holds until the next accept.
  - Both reset to 0.
- Undefined: neither port exists, and the logic is identical otherwise.

Decomposition:
- Package shift_seq_pkg holds:
  - state enum: IDLE, SHIFT, RESP (2-bit)
  - op constants: OP_LOAD=1'b0, OP_READ=1'b1
  - default WIDTH and CLK_DIV values
- One sub-module: shift_tick_gen. It holds the CLK_DIV divider and produces the one-cycle tick while enabled by SHIFT. It is cleared by Reset and on command accept.

Test Plan:
- The bench instantiates a behavioural WIDTH-bit shift register gated by ser_en_o. All cases use WIDTH=4, CLK_DIV=1 unless stated.
- Reset, then LOAD 0xA at cycle 0 -> ser_en_o high in cycles 1-4; ser_data_o = 1,0,1,0; rsp_valid_o in cycle 5 with rsp_data_o=0x0; chain = 0xA.
- READ following that LOAD -> ser_data_o = 1,0,1,0; rsp_data_o=0xA; chain still 0xA.
- LOAD 0x5 with rsp_ready_i held low for 3 cycles -> rsp_valid_o and rsp_data_o=0xA stable; cmd_ready_o=0 and busy_o=1 throughout; cmd_ready_o=1 one cycle after the handshake.
- Reset asserted in cycle 2 of a LOAD -> next cycle: ser_en_o=0, rsp_valid_o=0, cmd_ready_o=1, busy_o=0; no response is ever produced.
- CLK_DIV=3, LOAD 0xF -> ser_en_o pulses in cycles 3, 6, 9, 12 only; rsp_valid_o in cycle 13.
- With the macro defined: LOAD 0xB over contents 0x7 -> cmd_parity_o=1, rsp_data_o=0x7, rsp_parity_o=1.
